wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL take parameter CHUNK, default 8: width of the adder pass per cycle.
REQ-002 The block SHALL take parameter NCHUNK, default 4: passes per operation; W = CHUNK*NCHUNK; NCHUNK >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: request carries valid operands.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 The block SHALL have ports a and b, input, W bits each: operands.
REQ-008 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 The block SHALL have port sum, output, W bits: result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of bit W-1.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept condition: on an edge with IDLE and in_valid=1, the block SHALL latch a, b and cin into a carry register, clear the chunk index to 0, and enter RUN.
REQ-016 In RUN, each edge SHALL:
- add operand chunk[idx] with the carry register through one CHUNK-bit adder;
- write the CHUNK-bit result into sum chunk[idx] and the adder carry-out into the carry register;
- increment idx.
REQ-017 On the edge that processes idx = NCHUNK-1, the block SHALL enter DONE, so out_valid rises exactly NCHUNK edges after the accepting edge.
REQ-018 In DONE, cout SHALL equal the carry register, and sum/cout SHALL be held stable until out_ready=1.
REQ-019 DONE with out_ready=1 SHALL return to IDLE on that edge; in_ready SHALL be 1 in the following cycle.
REQ-020 No request SHALL be accepted in the same cycle as the result handshake; minimum initiation interval is NCHUNK+1 cycles.
REQ-021 in_valid and changes on a, b or cin during RUN or DONE SHALL be ignored and SHALL not corrupt the result.
REQ-022 Arithmetic SHALL be unsigned modulo 2^W, with the carry chain unbroken across chunk boundaries.
REQ-023 With NCHUNK=1, the block SHALL enter DONE one edge after accept.
REQ-024 sum and cout SHALL be don't-care outside DONE, but SHALL never be X after reset.

Reset
REQ-025 rst=1 SHALL asynchronously force:
- state = IDLE, idx = 0, carry register = 0;
- sum = 0, cout = 0, out_valid = 0, busy = 0;
- in_ready = 1 once rst deasserts.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abort the operation; no result SHALL be presented afterwards.

Configuration
REQ-027 With macro WIDE_ADD_SEQ_OVF_EN defined, the block SHALL add output port ovf (1 bit), equal in DONE to the signed two's-complement overflow of a+b+cin, and 0 otherwise and after reset.
REQ-028 Without WIDE_ADD_SEQ_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package wide_add_pkg SHALL hold:
- the FSM state typedef (IDLE, RUN, DONE);
- default CHUNK and NCHUNK constants.
REQ-030 The per-cycle adder SHALL be one instance of the team's existing rca_Nbit with N=CHUNK; no other sub-module SHALL be used.
REQ-031 The chunk index counter SHALL be $clog2(NCHUNK) bits wide, with a minimum of 1.

Verification (CHUNK=8, NCHUNK=4)
REQ-032 Bench SHALL cover: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid exactly 4 cycles after accept.
REQ-033 Bench SHALL cover: a=0, b=0, cin=1 -> sum=0x00000001, cout=0.
REQ-034 Bench SHALL cover: a=0x12345678, b=0x11111111, out_ready held 0 for 5 cycles -> sum=0x23456789 stable throughout, in_ready=0 until the handshake edge, then 1 the next cycle.
REQ-035 Bench SHALL cover: in_valid held high with new operands during RUN -> first result unaffected, second request accepted only after return to IDLE.
REQ-036 Bench SHALL cover: rst pulsed at RUN idx=2 -> out_valid=0, busy=0, in_ready=1 after deassert, no result emitted.
REQ-037 Bench SHALL cover, with WIDE_ADD_SEQ_OVF_EN: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, cout=0.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the chunked sequential wide adder.
// Contains the FSM state encoding and the default chunk geometry.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_CHUNK  = 8;
    localparam int DEFAULT_NCHUNK = 4;

    // A one-chunk build still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_Nbit.sv
// N-bit ripple-carry adder used as the per-cycle datapath of wide_add_seq.
module rca_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[N];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential W-bit adder: one CHUNK-bit ripple adder reused NCHUNK times per operation.
// Optional signed-overflow output ovf is built when WIDE_ADD_SEQ_OVF_EN is defined.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int CHUNK  = DEFAULT_CHUNK,
    parameter int NCHUNK = DEFAULT_NCHUNK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHUNK*NCHUNK-1:0]   a,
    input  logic [CHUNK*NCHUNK-1:0]   b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHUNK*NCHUNK-1:0]   sum,
    output logic                      cout,
    output logic                      busy
`ifdef WIDE_ADD_SEQ_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int W     = CHUNK * NCHUNK;
    localparam int IDX_W = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [W-1:0]     a_reg, a_next;
    logic [W-1:0]     b_reg, b_next;
    logic [W-1:0]     sum_reg, sum_next;
    logic             carry_reg, carry_next;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    // Operands are captured at accept so input changes during RUN/DONE cannot leak in.
    assign a_chunk = a_reg[idx_reg*CHUNK +: CHUNK];
    assign b_chunk = b_reg[idx_reg*CHUNK +: CHUNK];

    rca_Nbit #(
        .N(CHUNK)
    ) u_rca (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_reg),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                sum_next[idx_reg*CHUNK +: CHUNK] = chunk_sum;
                carry_next = chunk_cout;
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Handshake returns to IDLE only; a new accept needs a separate IDLE cycle.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign cout      = carry_reg;

`ifdef WIDE_ADD_SEQ_OVF_EN
    // Like-signed operands producing an opposite-signed result overflow, with or without cin.
    assign ovf = (state_reg == DONE)
              && (a_reg[W-1] == b_reg[W-1])
              && (sum_reg[W-1] != a_reg[W-1]);
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq (CHUNK=8, NCHUNK=4).
module tb_wide_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;
`ifdef WIDE_ADD_SEQ_OVF_EN
    logic        ovf;
`endif

    int compared;
    int mismatched;

    wide_add_seq #(
        .CHUNK (8),
        .NCHUNK(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a_in),
        .b        (b_in),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
`ifdef WIDE_ADD_SEQ_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid and returns the number of edges taken.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic [31:0] exp_sum, input logic exp_cout);
        int lat;
        a_in     = av;
        b_in     = bv;
        cin      = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_result(lat);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        $display("op %s: a=%08h b=%08h cin=%0d -> sum=%08h cout=%0d lat=%0d",
                 tag, av, bv, ci, sum, cout, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        cin        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Carry rippling through every chunk boundary
        run_op("ffff_plus_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        run_op("cin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
        run_op("chunk_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0);
        run_op("wrap_cin", 32'h89AB_CDEF, 32'h7654_3210, 1'b1, 32'h0000_0000, 1'b1);

        // Back-pressure: result held while out_ready is low, inputs wiggle
        a_in     = 32'h1234_5678;
        b_in     = 32'h1111_1111;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", 64'(sum), 64'h2345_6789);
            check("bp_cout", 64'(cout), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            a_in = $urandom;
            b_in = $urandom;
            cin  = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
        $display("op backpressure: sum=%08h held 5 cycles", sum);
        out_ready = 1'b1;
        check("bp_in_ready_pre", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_in_ready_post", 64'(in_ready), 64'd1);

        // in_valid held high with new operands during RUN/DONE
        a_in     = 32'h0000_FFFF;
        b_in     = 32'h0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in = 32'hAAAA_AAAA;
        b_in = 32'h5555_5555;
        cin  = 1'b1;
        wait_result(lat);
        check("hold_latency", 64'(lat), 64'd4);
        check("hold_sum1", 64'(sum), 64'h0001_0000);
        check("hold_cout1", 64'(cout), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_no_accept_busy", 64'(busy), 64'd0);
        check("hold_no_accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_second_busy", 64'(busy), 64'd1);
        wait_result(lat);
        check("hold_latency2", 64'(lat), 64'd4);
        check("hold_sum2", 64'(sum), 64'h0000_0000);
        check("hold_cout2", 64'(cout), 64'd1);
        $display("op hold_in_valid: second sum=%08h cout=%0d", sum, cout);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset pulsed mid-RUN at idx=2
        a_in     = 32'h1111_1111;
        b_in     = 32'h2222_2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        $display("op reset_abort: in_ready=%0d busy=%0d", in_ready, busy);

        // Signed overflow case (sum/cout checked in every build)
        a_in     = 32'h7FFF_FFFF;
        b_in     = 32'h0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("ovf_latency", 64'(lat), 64'd4);
        check("ovf_sum", 64'(sum), 64'h8000_0000);
        check("ovf_cout", 64'(cout), 64'd0);
`ifdef WIDE_ADD_SEQ_OVF_EN
        check("ovf_flag", 64'(ovf), 64'd1);
`endif
        $display("op signed_ovf: sum=%08h cout=%0d", sum, cout);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
        check("ovf_idle_zero", 64'(ovf), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
